// File: rtl/dds_voice_engine.sv
// Multi-voice DDS tone engine: one shared adder and multiplier are time-multiplexed
// over NUM_VOICES voices per sample tick, and the saturated mix is presented on data_out.
module dds_voice_engine #(
   parameter  int NUM_VOICES = 4,
   parameter  int PHASE_W    = 16,
   parameter  int OUT_W      = 16,
   parameter  int VOL_W      = 8,
   localparam int VID_W      = $clog2(NUM_VOICES),
   localparam int ADDR_W     = VID_W + 2
) (
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              sample_tick_in,
   input  logic [PHASE_W-1:0] data_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              data_valid_in,
   output logic [OUT_W-1:0]  data_out,
   output logic              data_valid_out,
   output logic              busy_out,
   output logic              overrun_out
);
   localparam int ACC_W  = OUT_W + VID_W;
   localparam int ADD_W  = (PHASE_W + 1 > ACC_W) ? PHASE_W + 1 : ACC_W;
   localparam int PROD_W = OUT_W + VOL_W + 1;
   localparam logic signed [OUT_W-1:0] OUT_PMAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_NMAX = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
   localparam logic signed [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] ACC_HI   = ACC_W'(OUT_PMAX);
   localparam logic signed [ACC_W-1:0] ACC_LO   = ACC_W'(OUT_MIN);

   typedef enum logic [2:0] {S_IDLE, S_ACC, S_WAVE, S_DCA, S_MIX, S_OUT} state_t;

   state_t state, state_nxt;

   logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_acc;
   logic [NUM_VOICES-1:0][PHASE_W-1:0] phase_incr;
   logic [NUM_VOICES-1:0][VOL_W-1:0]   volume;
   logic [NUM_VOICES-1:0][1:0]         wave_type;

   logic [VID_W-1:0]        voice;
   logic [14:0]             lfsr;
   logic signed [OUT_W-1:0] tmp;
   logic signed [ACC_W-1:0] mix_acc;
   logic [OUT_W-1:0]        data_q;
   logic                    overrun_q;

   logic [ADD_W-1:0]         add_a, add_b, add_sum;
   logic [PHASE_W-1:0]       p, pl;
   logic [OUT_W-1:0]         f, saw;
   logic signed [OUT_W-1:0]  wave, dca_val, clamped;
   logic signed [PROD_W-1:0] prod;

   wire [1:0]       reg_sel = addr_in[ADDR_W-1 -: 2];
   wire [VID_W-1:0] wr_v    = addr_in[VID_W-1:0];

   // FSM: state register
   always_ff @(posedge clk_in) begin
      if (reset_in) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sample_tick_in) state_nxt = S_ACC;
         S_ACC:   state_nxt = S_WAVE;
         S_WAVE:  state_nxt = S_DCA;
         S_DCA:   state_nxt = S_MIX;
         S_MIX:   state_nxt = (voice == VID_W'(NUM_VOICES - 1)) ? S_OUT : S_ACC;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs; data_out shows the fresh clamp during OUT, then holds it
   always_comb begin
      data_valid_out = (state == S_OUT);
      busy_out       = (state != S_IDLE);
      overrun_out    = overrun_q;
      data_out       = (state == S_OUT) ? clamped : data_q;
   end

   // Shared adder: phase accumulate in ACC (zero-extended), signed mix in MIX
   always_comb begin
      if (state == S_MIX) begin
         add_a = ADD_W'(mix_acc);
         add_b = ADD_W'(tmp);
      end else begin
         add_a = ADD_W'(phase_acc[voice]);
         add_b = ADD_W'(phase_incr[voice]);
      end
      add_sum = add_a + add_b;
   end

   always_comb begin
      p    = phase_acc[voice];
      pl   = {p[PHASE_W-2:0], 1'b0};
      f    = pl[PHASE_W-1 -: OUT_W] ^ {OUT_W{p[PHASE_W-1]}};
      saw  = p[PHASE_W-1 -: OUT_W];
      case (wave_type[voice])
         2'd0:    wave = p[PHASE_W-1] ? OUT_NMAX : OUT_PMAX;
         2'd1:    wave = {~saw[OUT_W-1], saw[OUT_W-2:0]};
         2'd2:    wave = {~f[OUT_W-1], f[OUT_W-2:0]};
         default: wave = lfsr[0] ? OUT_PMAX : OUT_NMAX;
      endcase
      prod    = PROD_W'(tmp) * PROD_W'($signed({1'b0, volume[voice]}));
      dca_val = OUT_W'(prod >>> VOL_W);
   end

   always_comb begin
      if (mix_acc > ACC_HI)      clamped = OUT_PMAX;
      else if (mix_acc < ACC_LO) clamped = OUT_MIN;
      else                       clamped = mix_acc[OUT_W-1:0];
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         phase_acc  <= '0;
         phase_incr <= '0;
         volume     <= '0;
         wave_type  <= '0;
         voice      <= '0;
         lfsr       <= 15'h7FFF;
         tmp        <= '0;
         mix_acc    <= '0;
         data_q     <= '0;
         overrun_q  <= 1'b0;
      end else begin
         overrun_q <= sample_tick_in && (state != S_IDLE);
         case (state)
            S_IDLE: if (sample_tick_in) begin
               mix_acc <= '0;
               voice   <= '0;
            end
            S_ACC: begin
               phase_acc[voice] <= add_sum[PHASE_W-1:0];
               if (add_sum[PHASE_W] && wave_type[voice] == 2'd3)
                  lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
            end
            S_WAVE: tmp <= wave;
            S_DCA:  tmp <= dca_val;
            S_MIX: begin
               mix_acc <= add_sum[ACC_W-1:0];
               voice   <= voice + VID_W'(1);
            end
            default: data_q <= clamped;
         endcase
         // Host writes come last so a phase set beats a same-cycle accumulate
         if (data_valid_in) begin
            case (reg_sel)
               2'd0:    phase_incr[wr_v] <= data_in;
               2'd1:    volume[wr_v]     <= data_in[VOL_W-1:0];
               2'd2:    wave_type[wr_v]  <= data_in[1:0];
               default: phase_acc[wr_v]  <= data_in;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dds_voice_engine.sv
// Self-checking bench for dds_voice_engine: directed frames plus randomized voice
// settings, compared against an arithmetic per-frame reference model.
module tb_dds_voice_engine;
   localparam int NV = 4;
   localparam int PW = 16;
   localparam int OW = 16;
   localparam int AW = 4;

   logic          clk_in = 1'b0;
   logic          reset_in, sample_tick_in, data_valid_in;
   logic [PW-1:0] data_in;
   logic [AW-1:0] addr_in;
   logic [OW-1:0] data_out;
   logic          data_valid_out, busy_out, overrun_out;

   dds_voice_engine #(.NUM_VOICES(NV), .PHASE_W(PW), .OUT_W(OW), .VOL_W(8)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .sample_tick_in(sample_tick_in),
      .data_in(data_in), .addr_in(addr_in), .data_valid_in(data_valid_in),
      .data_out(data_out), .data_valid_out(data_valid_out),
      .busy_out(busy_out), .overrun_out(overrun_out));

   always #5 clk_in = ~clk_in;

   int nvec = 0;
   int nerr = 0;
   int m_acc[NV], m_incr[NV], m_vol[NV], m_wt[NV];
   int m_lfsr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int v = 0; v < NV; v++) begin
         m_acc[v] = 0; m_incr[v] = 0; m_vol[v] = 0; m_wt[v] = 0;
      end
      m_lfsr = 'h7FFF;
   endtask

   // One frame of the reference: accumulate, synthesize, scale, sum, saturate
   task automatic model_frame(input bit ovr_en, input int ovr_val, output int res);
      int mix, s, w, fb;
      bit carry;
      mix = 0;
      for (int v = 0; v < NV; v++) begin
         s = m_acc[v] + m_incr[v];
         carry = (s > 65535);
         m_acc[v] = s % 65536;
         if (ovr_en && v == 0) m_acc[0] = ovr_val;
         if (carry && m_wt[v] == 3) begin
            fb = ((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 'h7FFF;
         end
         case (m_wt[v])
            0:       w = (m_acc[v] < 32768) ? 32767 : -32767;
            1:       w = m_acc[v] - 32768;
            2:       w = (m_acc[v] < 32768) ? 2 * m_acc[v] - 32768 : 98303 - 2 * m_acc[v];
            default: w = (m_lfsr & 1) ? 32767 : -32767;
         endcase
         w = (w * m_vol[v]) >>> 8;
         mix += w;
      end
      if (mix > 32767) mix = 32767;
      else if (mix < -32768) mix = -32768;
      res = mix & 'hFFFF;
   endtask

   task automatic wr(input int sel, input int v, input int d);
      addr_in = AW'((sel << 2) | v);
      data_in = PW'(d);
      data_valid_in = 1'b1;
      @(posedge clk_in); #1;
      data_valid_in = 1'b0;
      case (sel)
         0:       m_incr[v] = d & 'hFFFF;
         1:       m_vol[v]  = d & 'hFF;
         2:       m_wt[v]   = d & 3;
         default: m_acc[v]  = d & 'hFFFF;
      endcase
   endtask

   task automatic do_reset();
      reset_in = 1'b1; sample_tick_in = 1'b0; data_valid_in = 1'b0;
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      reset_in = 1'b0;
      model_clear();
   endtask

   // Tick, wait (bounded) for the output pulse, check timing, value and hold
   task automatic run_frame(input string tag, input bit ovr_en, input int ovr_val, output int obs);
      int exp, n, bcnt;
      model_frame(ovr_en, ovr_val, exp);
      chk({tag, " busy_pre"}, 32'(busy_out), 0);
      sample_tick_in = 1'b1;
      @(posedge clk_in); #1;
      sample_tick_in = 1'b0;
      n = 1; bcnt = 0;
      while (!data_valid_out && n < 40) begin
         if (busy_out) bcnt++;
         if (ovr_en && n == 1) begin
            addr_in = AW'(3 << 2); data_in = PW'(ovr_val); data_valid_in = 1'b1;
         end else data_valid_in = 1'b0;
         @(posedge clk_in); #1;
         n++;
      end
      data_valid_in = 1'b0;
      if (busy_out) bcnt++;
      obs = 32'(data_out);
      chk({tag, " latency"}, 32'(n), 17);
      chk({tag, " busy_cycles"}, 32'(bcnt), 17);
      chk({tag, " data"}, 32'(data_out), 32'(exp));
      @(posedge clk_in); #1;
      chk({tag, " dv_drop"}, 32'(data_valid_out), 0);
      chk({tag, " busy_drop"}, 32'(busy_out), 0);
      chk({tag, " hold"}, 32'(data_out), 32'(exp));
   endtask

   task automatic ovr_test(input string tag, input int tc);
      int exp, novr, ndv, dvc, obs;
      model_frame(1'b0, 0, exp);
      sample_tick_in = 1'b1;
      @(posedge clk_in); #1;
      novr = 0; ndv = 0; dvc = 0; obs = 0;
      for (int c = 1; c <= 40; c++) begin
         if (overrun_out) novr++;
         if (data_valid_out) begin ndv++; dvc = c; obs = 32'(data_out); end
         sample_tick_in = (c == tc);
         @(posedge clk_in); #1;
      end
      sample_tick_in = 1'b0;
      chk({tag, " ovr_pulses"}, 32'(novr), 1);
      chk({tag, " dv_pulses"}, 32'(ndv), 1);
      chk({tag, " dv_cycle"}, 32'(dvc), 17);
      chk({tag, " data"}, 32'(obs), 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int obs, cnt;
      reset_in = 1'b1; sample_tick_in = 1'b0; data_valid_in = 1'b0;
      data_in = '0; addr_in = '0;
      do_reset();
      chk("rst data_out", 32'(data_out), 0);
      chk("rst dv", 32'(data_valid_out), 0);
      chk("rst busy", 32'(busy_out), 0);
      chk("rst overrun", 32'(overrun_out), 0);

      run_frame("zero", 1'b0, 0, obs);
      chk("zero const", 32'(obs), 0);

      // Square on voice 0 walking through half a cycle and a wrap
      wr(0, 0, 'h1000); wr(1, 0, 'hFF);
      for (int t = 1; t <= 16; t++) begin
         run_frame("square", 1'b0, 0, obs);
         if (t == 1)  chk("square t1", 32'(obs), 'h7F7F);
         if (t == 8)  chk("square t8", 32'(obs), 'h8080);
         if (t == 16) chk("square t16", 32'(obs), 'h7F7F);
      end

      wr(2, 0, 1); wr(0, 0, 'h4000); wr(3, 0, 0);
      run_frame("saw1", 1'b0, 0, obs); chk("saw1 const", 32'(obs), 'hC040);
      run_frame("saw2", 1'b0, 0, obs); chk("saw2 const", 32'(obs), 'h0000);
      wr(1, 0, 0);
      run_frame("saw_v0", 1'b0, 0, obs); chk("saw_v0 const", 32'(obs), 'h0000);

      // All voices at full scale: both saturation rails
      for (int v = 0; v < NV; v++) begin
         wr(2, v, 0); wr(1, v, 'hFF); wr(0, v, 0); wr(3, v, 0);
      end
      run_frame("clamp_hi", 1'b0, 0, obs); chk("clamp_hi const", 32'(obs), 'h7FFF);
      for (int v = 0; v < NV; v++) wr(3, v, 'h8000);
      run_frame("clamp_lo", 1'b0, 0, obs); chk("clamp_lo const", 32'(obs), 'h8000);

      // Phase write in the ACC cycle of voice 0 overrides the accumulate
      for (int v = 1; v < NV; v++) wr(1, v, 0);
      wr(2, 0, 1); wr(0, 0, 'h1000); wr(3, 0, 0);
      run_frame("wr_wins", 1'b1, 'hC000, obs); chk("wr_wins const", 32'(obs), 'h3FC0);

      ovr_test("ovr_c5", 5);
      ovr_test("ovr_out", 17);

      // Randomized voice settings, including noise
      for (int f = 0; f < 24; f++) begin
         if (f % 6 == 0) begin
            for (int v = 0; v < NV; v++) begin
               wr(0, v, int'($urandom_range(0, 65535)));
               wr(1, v, int'($urandom_range(0, 255)));
               wr(2, v, int'($urandom_range(0, 3)));
               wr(3, v, int'($urandom_range(0, 65535)));
            end
         end
         run_frame("rand", 1'b0, 0, obs);
      end

      // Tick coinciding with reset must not start a frame
      reset_in = 1'b1; sample_tick_in = 1'b1;
      @(posedge clk_in); #1;
      reset_in = 1'b0; sample_tick_in = 1'b0;
      model_clear();
      chk("rst_tick busy", 32'(busy_out), 0);

      // Reset eight cycles into a frame aborts it and clears all voice state
      wr(0, 1, 'h2345); wr(1, 1, 'hC0); wr(2, 1, 2);
      sample_tick_in = 1'b1;
      @(posedge clk_in); #1;
      sample_tick_in = 1'b0;
      for (int c = 1; c < 8; c++) begin @(posedge clk_in); #1; end
      reset_in = 1'b1;
      @(posedge clk_in); #1;
      reset_in = 1'b0;
      model_clear();
      chk("abort busy", 32'(busy_out), 0);
      chk("abort data_out", 32'(data_out), 0);
      cnt = 0;
      for (int c = 0; c < 25; c++) begin
         if (data_valid_out) cnt++;
         @(posedge clk_in); #1;
      end
      chk("abort no_dv", 32'(cnt), 0);
      run_frame("post_abort", 1'b0, 0, obs);
      chk("post_abort const", 32'(obs), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
